uart_tx_arbiter: RTL

Shares one uart_tx serialiser among NUM_REQ byte-stream requesters, so several blocks (command responder, status reporter, debug echo) can drive the single board TX pin.
- Round-robin arbitration at packet granularity: the grant is locked from a requester's first byte until its byte flagged last is transmitted.
- A mid-packet stall timeout releases the lock so that a hung requester cannot block the pin.
- Sits between requesters and uart_tx; it is the transmit-side counterpart of uart_rx.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit-side arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, TAG, SEND, WAIT, HOLD)
//   TAG_NIBBLE   : upper nibble of the optional source-tag byte
//   CLKS_PER_BIT : default serialiser bit period in system clocks
//   clog2()      : ceiling log2 for sizing index and counter fields
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    SEND,
    WAIT,
    HOLD
  } arb_state_t;

  localparam logic [3:0] TAG_NIBBLE   = 4'hA;
  localparam int         CLKS_PER_BIT = 217;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   valid : request vector, one bit per requester
//   ptr   : requester with highest priority this round
//   any   : at least one request is set
//   idx   : first set request found searching upward from ptr with wrap
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  always_comb begin
    int slot;
    slot = 0;
    any  = 1'b0;
    idx  = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      slot = (int'(ptr) + i) % N;
      if (valid[slot[IDW-1:0]]) begin
        any = 1'b1;
        idx = slot[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serialiser among NUM_REQ byte-stream
// requesters with packet-granular round-robin arbitration. The grant stays
// locked from a packet's first byte to its last; a requester that stalls
// mid-packet for TIMEOUT_CLKS clocks loses the lock.
//
// Optional build macro UART_TX_SRC_TAG_EN: every packet is preceded by a tag
// byte {4'hA, 1'b0, owner id} sent from an extra TAG state.
//
// Ports:
//   i_clock      system clock
//   i_reset_n    synchronous active-low reset
//   i_req_valid  per-requester byte valid
//   i_req_last   per-requester byte is last of packet
//   i_req_byte   per-requester byte, requester k on [8k+7:8k]
//   o_req_ready  one-cycle accept pulse, one-hot or zero
//   o_grant_id   current / most recent owner
//   o_busy       high whenever the FSM is not IDLE
//   o_timeout    one-cycle pulse on forced release of a stalled packet
//   o_tx_dv      one-cycle load strobe to uart_tx
//   o_tx_byte    byte to uart_tx
//   i_tx_active  uart_tx serialising (checked only)
//   i_tx_done    uart_tx end-of-stop-bit pulse
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 100 * CLKS_PER_BIT
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ-1:0]          i_req_last,
  input  logic [8*NUM_REQ-1:0]        i_req_byte,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                        o_busy,
  output logic                        o_timeout,
  output logic                        o_tx_dv,
  output logic [7:0]                  o_tx_byte,
  input  logic                        i_tx_active,
  input  logic                        i_tx_done
);

  localparam int IDW  = clog2(NUM_REQ);
  localparam int CNTW = clog2(TIMEOUT_CLKS);

  arb_state_t       state;
  logic [IDW-1:0]   ptr;
  logic             last_q;
  logic [CNTW-1:0]  hold_cnt;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic             owner_valid;
  logic [7:0]       req_bytes [NUM_REQ];
`ifdef UART_TX_SRC_TAG_EN
  logic             tag_q;
`endif

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = i_req_byte[8*k +: 8];
  end

  assign owner_valid = i_req_valid[o_grant_id];

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .valid (i_req_valid),
    .ptr   (ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

`ifdef UART_TX_SRC_TAG_EN
  function automatic logic [7:0] tag_byte(input logic [IDW-1:0] id);
    return {TAG_NIBBLE, 1'b0, 3'(id)};
  endfunction
`endif

  // Outputs are registered: the cycle spent in SEND (or TAG) is the cycle in
  // which o_tx_dv and o_req_ready are visible, so they are loaded on entry.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      last_q      <= 1'b0;
      hold_cnt    <= '0;
      o_req_ready <= '0;
      o_grant_id  <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_tx_dv     <= 1'b0;
      o_tx_byte   <= '0;
`ifdef UART_TX_SRC_TAG_EN
      tag_q       <= 1'b0;
`endif
    end else begin
      o_tx_dv     <= 1'b0;
      o_req_ready <= '0;
      o_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            o_grant_id <= pick_idx;
            o_busy     <= 1'b1;
            o_tx_dv    <= 1'b1;
`ifdef UART_TX_SRC_TAG_EN
            state      <= TAG;
            o_tx_byte  <= tag_byte(pick_idx);
`else
            state       <= SEND;
            o_tx_byte   <= req_bytes[pick_idx];
            o_req_ready <= onehot(pick_idx);
`endif
          end
        end
`ifdef UART_TX_SRC_TAG_EN
        TAG: begin
          tag_q <= 1'b1;
          state <= WAIT;
        end
`endif
        SEND: begin
          // Requester holds last stable until the accept, so sample it here.
          last_q <= i_req_last[o_grant_id];
          state  <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
`ifdef UART_TX_SRC_TAG_EN
            // The tag is never subject to the stall timeout.
            if (tag_q) begin
              tag_q       <= 1'b0;
              state       <= SEND;
              o_tx_dv     <= 1'b1;
              o_tx_byte   <= req_bytes[o_grant_id];
              o_req_ready <= onehot(o_grant_id);
            end else
`endif
            if (last_q) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              ptr    <= next_ptr(o_grant_id);
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (owner_valid) begin
            state       <= SEND;
            o_tx_dv     <= 1'b1;
            o_tx_byte   <= req_bytes[o_grant_id];
            o_req_ready <= onehot(o_grant_id);
          end else if (hold_cnt == CNTW'(TIMEOUT_CLKS - 1)) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            ptr       <= next_ptr(o_grant_id);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // A new load strobe while the serialiser is still busy would corrupt a byte.
  assert property (@(posedge i_clock) disable iff (!i_reset_n)
                   !(o_tx_dv && i_tx_active));

endmodule
